// File: rtl/align_add_seq.sv
// Multi-cycle front end of a binary16 adder: orders operands by magnitude,
// aligns the smaller mantissa one bit per cycle, then adds or subtracts.
module align_add_seq #(
  parameter int MAX_SHIFT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  exp,
  output logic [10:0] Rm,
  output logic        carry,
  output logic        swap,
  output logic        As,
  output logic        Bs,
  output logic        arround
);

  localparam int DATA_W = 16;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 11;
  localparam logic [EXP_W-1:0] MAX_D = EXP_W'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, SHIFT, ADD, DONE} state_t;

  typedef struct packed {
    logic [MANT_W-1:0] rm;
    logic              carry;
    logic              arround;
  } sum_t;

  state_t state, state_next;

  // Effective add keeps the bit shifted out on carry as the round increment;
  // without carry the last aligned-out bit (guard) plays that role.
  function automatic sum_t add_round(input logic [MANT_W-1:0] ml,
                                     input logic [MANT_W-1:0] ms,
                                     input logic              guard,
                                     input logic              eff_sub);
    sum_t          r;
    logic [MANT_W:0] sum;
    r   = '0;
    sum = {1'b0, ml} + {1'b0, ms};
    if (eff_sub) begin
      r.rm = ml - ms;
    end else if (sum[MANT_W]) begin
      r.rm      = sum[MANT_W:1];
      r.carry   = 1'b1;
      r.arround = sum[0];
    end else begin
      r.rm      = sum[MANT_W-1:0];
      r.arround = guard;
    end
    return r;
  endfunction

  logic [EXP_W-1:0]  a_exp, b_exp, a_eff, b_eff, l_exp, l_eff, s_eff, diff, d_in;
  logic [MANT_W-1:0] a_mant, b_mant, l_mant, s_mant;
  logic              swap_in;

  always_comb begin
    a_exp   = A[DATA_W-2:MANT_W-1];
    b_exp   = B[DATA_W-2:MANT_W-1];
    a_mant  = {(a_exp != '0), A[MANT_W-2:0]};
    b_mant  = {(b_exp != '0), B[MANT_W-2:0]};
    a_eff   = (a_exp == '0) ? EXP_W'(1) : a_exp;
    b_eff   = (b_exp == '0) ? EXP_W'(1) : b_exp;
    swap_in = (B[DATA_W-2:0] > A[DATA_W-2:0]);
    l_exp   = swap_in ? b_exp  : a_exp;
    l_eff   = swap_in ? b_eff  : a_eff;
    s_eff   = swap_in ? a_eff  : b_eff;
    l_mant  = swap_in ? b_mant : a_mant;
    s_mant  = swap_in ? a_mant : b_mant;
    diff    = l_eff - s_eff;
    d_in    = (diff > MAX_D) ? MAX_D : diff;
  end

  logic              a_sign_p0, b_sign_p0, swap_p0, guard_p0, sticky_p0;
  logic [EXP_W-1:0]  exp_l_p0, count_p0;
  logic [MANT_W-1:0] m_l_p0, m_s_p0;
  sum_t              sum_p1;

  assign sum_p1 = add_round(m_l_p0, m_s_p0, guard_p0, a_sign_p0 ^ b_sign_p0);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (d_in != '0) ? SHIFT : ADD;
      end
      SHIFT: if (count_p0 == EXP_W'(1)) state_next = ADD;
      ADD:   state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sign_p0 <= 1'b0;
      b_sign_p0 <= 1'b0;
      swap_p0   <= 1'b0;
      guard_p0  <= 1'b0;
      sticky_p0 <= 1'b0;
      exp_l_p0  <= '0;
      count_p0  <= '0;
      m_l_p0    <= '0;
      m_s_p0    <= '0;
      exp       <= '0;
      Rm        <= '0;
      carry     <= 1'b0;
      swap      <= 1'b0;
      As        <= 1'b0;
      Bs        <= 1'b0;
      arround   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        // Capture: operands ordered and shift distance fixed
        IDLE: if (in_valid) begin
          a_sign_p0 <= A[DATA_W-1];
          b_sign_p0 <= B[DATA_W-1];
          swap_p0   <= swap_in;
          exp_l_p0  <= l_exp;
          m_l_p0    <= l_mant;
          m_s_p0    <= s_mant;
          count_p0  <= d_in;
          guard_p0  <= 1'b0;
          sticky_p0 <= 1'b0;
        end
        // Serial alignment: one bit per cycle into guard, older guards into sticky
        SHIFT: begin
          m_s_p0    <= m_s_p0 >> 1;
          guard_p0  <= m_s_p0[0];
          sticky_p0 <= sticky_p0 | guard_p0;
          count_p0  <= count_p0 - EXP_W'(1);
        end
        // Add/subtract: result fields are only ever written here
        ADD: begin
          exp     <= exp_l_p0;
          Rm      <= sum_p1.rm;
          carry   <= sum_p1.carry;
          arround <= sum_p1.arround;
          swap    <= swap_p0;
          As      <= a_sign_p0;
          Bs      <= b_sign_p0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_align_add_seq.sv
// Scoreboard bench for align_add_seq: expected fields and latency are queued
// when an operand pair is sent and checked when out_valid appears.
module tb_align_add_seq;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        in_ready, out_valid, carry, swap, As, Bs, arround;
  logic [4:0]  exp;
  logic [10:0] Rm;
  logic [20:0] obs;

  align_add_seq #(.MAX_SHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .exp(exp), .Rm(Rm), .carry(carry), .swap(swap), .As(As), .Bs(Bs),
    .arround(arround)
  );

  always #5 clk = ~clk;
  assign obs = {exp, Rm, carry, swap, As, Bs, arround};

  typedef struct {
    logic [20:0] f;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [20:0] pack(input logic [4:0] e, input logic [10:0] rm,
                                       input logic c, input logic sw, input logic as,
                                       input logic bs, input logic ar);
    return {e, rm, c, sw, as, bs, ar};
  endfunction

  // Reference model: align in one step, take guard as the last bit shifted out.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t        r;
    logic        sw, g, c, ar;
    logic [15:0] l, s;
    logic [11:0] ms_ext;
    logic [10:0] ml, mss, rm;
    int          el, es, d, sum;
    sw  = (b[14:0] > a[14:0]);
    l   = sw ? b : a;
    s   = sw ? a : b;
    ml  = {(l[14:10] != 0), l[9:0]};
    ms_ext = {1'b0, (s[14:10] != 0), s[9:0]};
    el  = (l[14:10] == 0) ? 1 : int'(l[14:10]);
    es  = (s[14:10] == 0) ? 1 : int'(s[14:10]);
    d   = el - es;
    if (d > 12) d = 12;
    g   = (d > 0) ? ms_ext[d-1] : 1'b0;
    mss = ms_ext[10:0] >> d;
    c   = 1'b0;
    ar  = 1'b0;
    if (a[15] == b[15]) begin
      sum = int'(ml) + int'(mss);
      c   = (sum >= 2048);
      rm  = c ? 11'(sum / 2) : 11'(sum);
      ar  = c ? (sum % 2 == 1) : g;
    end else begin
      rm = ml - mss;
    end
    r.f   = pack(l[14:10], rm, c, sw, a[15], b[15], ar);
    r.lat = d + 1;
    return r;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_hs out_valid,in_ready got %b want 01", {out_valid, in_ready});
    end
    checks++;
    if (obs !== 21'd0) begin
      errors++;
      $display("FAIL reset_fields got %h want 0", obs);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_plan_vectors();
    logic [15:0] va [4] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h7800};
    logic [15:0] vb [4] = '{16'h4000, 16'h3C00, 16'hBC00, 16'h0401};
    logic [20:0] vf [4];
    int          vl [4] = '{2, 1, 2, 13};
    int          edges;
    exp_t        e, cur;
    vf[0] = pack(5'd16, 11'h600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vf[1] = pack(5'd15, 11'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vf[2] = pack(5'd16, 11'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vf[3] = pack(5'd30, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      e.f = vf[k];
      e.lat = vl[k];
      sb.push_back(e);
      send(va[k], vb[k]);
      wait_valid(edges);
      cur = sb.pop_front();
      checks++;
      if (edges !== cur.lat) begin
        errors++;
        $display("FAIL plan%0d_latency got %0d want %0d", k, edges, cur.lat);
      end
      checks++;
      if (obs !== cur.f) begin
        errors++;
        $display("FAIL plan%0d_fields got %h want %h", k, obs, cur.f);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int          edges;
    exp_t        cur;
    logic [20:0] snap;
    sb.push_back(model(16'h3C00, 16'h4000));
    send(16'h3C00, 16'h4000);
    wait_valid(edges);
    cur = sb.pop_front();
    checks++;
    if (obs !== cur.f) begin
      errors++;
      $display("FAIL bp_fields got %h want %h", obs, cur.f);
    end
    snap = cur.f;
    A = 16'h3555; B = 16'h1234; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, obs} !== {2'b10, snap}) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%b r=%b %h want v=1 r=0 %h",
                 i, out_valid, in_ready, obs, snap);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got %b want 01", {out_valid, in_ready});
    end
    checks++;
    if (obs !== snap) begin
      errors++;
      $display("FAIL bp_hold_after got %h want %h", obs, snap);
    end
  endtask

  task automatic test_reset_mid();
    int   pulses, edges;
    exp_t cur;
    send(16'h4C00, 16'h2C00);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, obs} !== {2'b01, 21'd0}) begin
      errors++;
      $display("FAIL rstmid_async got v=%b r=%b %h want v=0 r=1 0",
               out_valid, in_ready, obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rstmid_no_pulse got %0d want 0", pulses);
    end
    sb.push_back(model(16'h4C00, 16'h2C00));
    send(16'h4C00, 16'h2C00);
    wait_valid(edges);
    cur = sb.pop_front();
    checks++;
    if (edges !== cur.lat || obs !== cur.f) begin
      errors++;
      $display("FAIL rstmid_next got lat=%0d %h want lat=%0d %h", edges, obs, cur.lat, cur.f);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int          edges;
    exp_t        cur;
    logic [15:0] a, b;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (k % 4 == 0) b = {~a[15], a[14:0]};
      if (k % 4 == 1) b = {a[15], a[14:10] - 5'd1, 10'($urandom)};
      sb.push_back(model(a, b));
      send(a, b);
      wait_valid(edges);
      cur = sb.pop_front();
      checks++;
      if (edges !== cur.lat || obs !== cur.f) begin
        errors++;
        $display("FAIL b2b%0d A=%h B=%h got lat=%0d %h want lat=%0d %h",
                 k, a, b, edges, obs, cur.lat, cur.f);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
